poly_sched: RTL

POLY_SCHED -- requirements
Module: poly_sched

---
 rtl/poly_sched.sv | 107 ++++++++++
 1 files changed

// File: rtl/poly_sched.sv
// rtl/poly_sched.sv - two-requester scheduler sharing one 8-bit ALU for A*X*X + B*X + C
module poly_sched #(
  parameter int FAIR = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [31:0] Op0,
  input  logic [31:0] Op1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Done0,
  output logic        Done1,
  output logic [7:0]  Result,
  output logic        Busy,
  output logic        Grant
);

  typedef enum logic [2:0] {IDLE, LOAD, M0, M1, M2, S0, S1, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a, b, c, x, t;
  logic        last;
  logic        win;
  logic [31:0] op_sel;
  logic [7:0]  alu_l, alu_r, alu_y;
  logic        alu_mul;
  logic [15:0] prod;

  always_comb begin
    if (Req0 && Req1) win = (FAIR != 0) ? ~last : 1'b0;
    else              win = Req1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Req0 || Req1) state_nxt = LOAD;
      LOAD:    state_nxt = M0;
      M0:      state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = S0;
      S0:      state_nxt = S1;
      S1:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single shared ALU: the state selects operands and whether to add or multiply.
  always_comb begin
    alu_l   = a;
    alu_r   = x;
    alu_mul = 1'b1;
    case (state)
      M1: begin alu_l = b; alu_r = x; end
      M2: begin alu_l = t; alu_r = x; end
      S0: begin alu_l = t; alu_r = b; alu_mul = 1'b0; end
      S1: begin alu_l = t; alu_r = c; alu_mul = 1'b0; end
      default: ;
    endcase
  end

  assign prod   = alu_l * alu_r;
  assign alu_y  = alu_mul ? prod[7:0] : alu_l + alu_r;
  assign op_sel = Grant ? Op1 : Op0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      a      <= 8'd0;
      b      <= 8'd0;
      c      <= 8'd0;
      x      <= 8'd0;
      t      <= 8'd0;
      Result <= 8'd0;
      Grant  <= 1'b0;
      last   <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (Req0 || Req1) begin
          Grant <= win;
          last  <= win;
        end
        LOAD: begin
          a <= op_sel[31:24];
          b <= op_sel[23:16];
          c <= op_sel[15:8];
          x <= op_sel[7:0];
        end
        M0, M2, S0: t <= alu_y;
        M1:         b <= alu_y;
        S1:         Result <= alu_y;
        default: ;
      endcase
    end
  end

  assign Ack0  = (state == LOAD) && !Grant;
  assign Ack1  = (state == LOAD) &&  Grant;
  assign Done0 = (state == DONE) && !Grant;
  assign Done1 = (state == DONE) &&  Grant;
  assign Busy  = (state != IDLE);

endmodule
